// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences the PLL reset, qualifies lock and releases the system reset once lock is stable.
// Optional output-frequency watchdog is built when PLL_FREQ_CHECK_EN is defined.
module pll_supervisor #(
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned WINDOW        = 50000,
    parameter int unsigned FREQ_MIN      = 7100,
    parameter int unsigned FREQ_MAX      = 7220
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        meas_clk,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic        pll_ok,
    output logic        fault,
    output logic [2:0]  retries,
    output logic [15:0] freq_count
);
    localparam int unsigned T_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int unsigned T_MAX  = (T_MAX0 > RST_PULSE) ? T_MAX0 : RST_PULSE;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       retries_q, retries_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             pll_ok_q, pll_ok_d;
    logic             fault_q, fault_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_sync_q, lock_sync_d;
    logic             freq_fault;
    logic             retry;

    always_comb begin
        lock_meta_d = pll_locked;
        lock_sync_d = lock_meta_q;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
        end
    end

`ifdef PLL_FREQ_CHECK_EN
    localparam int unsigned      WIN_W    = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [15:0]      F_MIN    = 16'(FREQ_MIN);
    localparam logic [15:0]      F_MAX    = 16'(FREQ_MAX);

    logic             meas_meta_q, meas_meta_d;
    logic             meas_sync_q, meas_sync_d;
    logic             meas_prev_q, meas_prev_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic [15:0]      freq_count_q, freq_count_d;
    logic             strike_q, strike_d;
    logic [15:0]      cnt_inc;
    logic             win_end;
    logic             win_bad;

    // The window runs free in every state; only the strike logic cares about RUN.
    always_comb begin
        meas_meta_d  = meas_clk;
        meas_sync_d  = meas_meta_q;
        meas_prev_d  = meas_sync_q;
        cnt_inc      = edge_cnt_q;
        if (meas_sync_q && !meas_prev_q && edge_cnt_q != 16'hFFFF)
            cnt_inc = edge_cnt_q + 16'd1;
        win_end      = (win_q == WIN_LAST);
        win_bad      = (cnt_inc < F_MIN) || (cnt_inc > F_MAX);
        win_d        = win_end ? '0 : win_q + WIN_ONE;
        edge_cnt_d   = win_end ? 16'd0 : cnt_inc;
        freq_count_d = win_end ? cnt_inc : freq_count_q;
        strike_d     = strike_q;
        freq_fault   = 1'b0;
        if (state_q != S_RUN) begin
            strike_d = 1'b0;
        end else if (win_end) begin
            freq_fault = win_bad && strike_q;
            strike_d   = win_bad;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            meas_meta_q  <= 1'b0;
            meas_sync_q  <= 1'b0;
            meas_prev_q  <= 1'b0;
            win_q        <= '0;
            edge_cnt_q   <= 16'd0;
            freq_count_q <= 16'd0;
            strike_q     <= 1'b0;
        end else begin
            meas_meta_q  <= meas_meta_d;
            meas_sync_q  <= meas_sync_d;
            meas_prev_q  <= meas_prev_d;
            win_q        <= win_d;
            edge_cnt_q   <= edge_cnt_d;
            freq_count_q <= freq_count_d;
            strike_q     <= strike_d;
        end
    end

    assign freq_count = freq_count_q;
`else
    logic unused_meas;

    assign unused_meas = meas_clk;
    assign freq_fault  = 1'b0;
    assign freq_count  = 16'd0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retries_d = retries_q;
        retry     = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                timer_d = timer_q + TMR_ONE;
                if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                timer_d = timer_q + TMR_ONE;
                if (lock_sync_q)                 state_d = S_STABILIZE;
                else if (timer_q == LOCK_LAST)   retry   = 1'b1;
            end
            S_STABILIZE: begin
                timer_d = timer_q + TMR_ONE;
                // Lock loss wins over a simultaneous timer expiry.
                if (!lock_sync_q)                retry   = 1'b1;
                else if (timer_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_sync_q || freq_fault) retry = 1'b1;
            end
            default: state_d = S_FAULT;
        endcase

        if (retry) begin
            if (retries_q == RETRY_MAX) begin
                state_d = S_FAULT;
            end else begin
                retries_d = retries_q + 3'd1;
                state_d   = S_RESET_PLL;
            end
        end

        if (state_d != state_q) timer_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_n_d = (state_d == S_RUN);
        pll_ok_d    = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            retries_q   <= 3'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ok_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retries_q   <= retries_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_ok_q    <= pll_ok_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ok    = pll_ok_q;
    assign fault     = fault_q;
    assign retries   = retries_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: vector table for the lock/retry timeline, hand sequences for
// lock timeout, asynchronous reset and the frequency watchdog (both builds of PLL_FREQ_CHECK_EN).
module tb_pll_supervisor;
    logic        refclk;
    logic        rst_n;
    logic        pll_locked;
    logic        meas_clk;
    logic        pll_rst;
    logic        sys_rst_n;
    logic        pll_ok;
    logic        fault;
    logic [2:0]  retries;
    logic [15:0] freq_count;

    int n_chk  = 0;
    int n_fail = 0;
    int tnow   = 0;
    int meas_half = 4;

    typedef struct {
        int t;
        int lk;
        int prst;
        int srst;
        int ok;
        int flt;
        int ret;
    } vec_t;

    vec_t vecs [25];

    pll_supervisor #(
        .RST_PULSE    (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(16),
        .MAX_RETRIES  (2),
        .WINDOW       (100),
        .FREQ_MIN     (10),
        .FREQ_MAX     (20)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .meas_clk  (meas_clk),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .pll_ok    (pll_ok),
        .fault     (fault),
        .retries   (retries),
        .freq_count(freq_count)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    initial begin
        meas_clk = 1'b0;
        forever begin
            repeat (meas_half) @(negedge refclk);
            meas_clk = ~meas_clk;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, got, exp, tnow);
        end
    endtask

    task automatic chk_outs(input string tag, input int prst, input int srst, input int ok,
                            input int flt, input int ret);
        chk({tag, " pll_rst"},   int'(pll_rst),   prst);
        chk({tag, " sys_rst_n"}, int'(sys_rst_n), srst);
        chk({tag, " pll_ok"},    int'(pll_ok),    ok);
        chk({tag, " fault"},     int'(fault),     flt);
        chk({tag, " retries"},   int'(retries),   ret);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge refclk);
        tnow += n;
    endtask

    // Assert reset mid-cycle: outputs must take reset values with no clock edge in between.
    task automatic pulse_reset(input string tag);
        @(negedge refclk);
        #3 rst_n = 1'b0;
        #1;
        chk_outs({tag, " async rst"}, 1, 0, 0, 0, 0);
        chk({tag, " async rst freq_count"}, int'(freq_count), 0);
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        tnow  = 0;
    endtask

    initial begin
        int a;
        int b;
        rst_n      = 1'b1;
        pll_locked = 1'b0;

        //          t    lk prst srst ok flt ret
        vecs = '{
            '{  0,  0,  1,  0,  0,  0,  0},
            '{  3,  0,  1,  0,  0,  0,  0},
            '{  4,  0,  0,  0,  0,  0,  0},
            '{ 24,  1,  0,  0,  0,  0,  0},
            '{ 42,  1,  0,  0,  0,  0,  0},
            '{ 43,  1,  0,  1,  1,  0,  0},
            '{ 50,  0,  0,  1,  1,  0,  0},
            '{ 52,  0,  0,  1,  1,  0,  0},
            '{ 53,  0,  1,  0,  0,  0,  1},
            '{ 56,  0,  1,  0,  0,  0,  1},
            '{ 57,  0,  0,  0,  0,  0,  1},
            '{ 60,  1,  0,  0,  0,  0,  1},
            '{ 69,  0,  0,  0,  0,  0,  1},
            '{ 70,  1,  0,  0,  0,  0,  1},
            '{ 71,  1,  0,  0,  0,  0,  1},
            '{ 72,  1,  1,  0,  0,  0,  2},
            '{ 75,  1,  1,  0,  0,  0,  2},
            '{ 76,  1,  0,  0,  0,  0,  2},
            '{ 92,  1,  0,  0,  0,  0,  2},
            '{ 93,  1,  0,  1,  1,  0,  2},
            '{100,  0,  0,  1,  1,  0,  2},
            '{102,  0,  0,  1,  1,  0,  2},
            '{103,  0,  1,  0,  0,  1,  2},
            '{110,  1,  1,  0,  0,  1,  2},
            '{130,  1,  1,  0,  0,  1,  2}
        };

        // Lock after reset, loss in RUN, 1-cycle glitch in STABILIZE, loss at max retries -> FAULT.
        pulse_reset("init");
        for (int i = 0; i < $size(vecs); i++) begin
            step(vecs[i].t - tnow);
            chk_outs($sformatf("vec%0d t=%0d", i, vecs[i].t),
                     vecs[i].prst, vecs[i].srst, vecs[i].ok, vecs[i].flt, vecs[i].ret);
            pll_locked = (vecs[i].lk != 0);
        end

        // Never locks: three attempts of 4+100 cycles, then terminal FAULT.
        pll_locked = 1'b0;
        pulse_reset("nolock");
        step(103); chk_outs("nolock t=103", 0, 0, 0, 0, 0);
        step(1);   chk_outs("nolock t=104", 1, 0, 0, 0, 1);
        step(103); chk_outs("nolock t=207", 0, 0, 0, 0, 1);
        step(1);   chk_outs("nolock t=208", 1, 0, 0, 0, 2);
        step(103); chk_outs("nolock t=311", 0, 0, 0, 0, 2);
        step(1);   chk_outs("nolock t=312", 1, 0, 0, 1, 2);
        step(88);  chk_outs("nolock t=400", 1, 0, 0, 1, 2);

        // Frequency watchdog: period-8 meas_clk holds RUN, then period 4 trips on the 2nd bad window.
        pll_locked = 1'b1;
        pulse_reset("freq");
        step(20);  chk("freq t=20 pll_ok", int'(pll_ok), 0);
        step(1);   chk_outs("freq t=21", 0, 1, 1, 0, 0);
        step(180); a = int'(freq_count);
        step(100); b = int'(freq_count);
`ifdef PLL_FREQ_CHECK_EN
        chk("freq p8 window pair 12/13", int'((a == 12 && b == 13) || (a == 13 && b == 12)), 1);
        chk("freq p8 two-window sum", a + b, 25);
`else
        chk("freq off window A", a, 0);
        chk("freq off window B", b, 0);
`endif
        chk_outs("freq t=301", 0, 1, 1, 0, 0);
        meas_half = 2;
        step(99);
`ifdef PLL_FREQ_CHECK_EN
        chk("freq 1st bad window over max", int'(freq_count > 16'd20), 1);
`else
        chk("freq off t=400 freq_count", int'(freq_count), 0);
`endif
        chk_outs("freq t=400 first bad held", 0, 1, 1, 0, 0);
        step(99);  chk_outs("freq t=499", 0, 1, 1, 0, 0);
        step(1);
`ifdef PLL_FREQ_CHECK_EN
        chk_outs("freq t=500 second bad retry", 1, 0, 0, 0, 1);
        chk("freq t=500 freq_count", int'(freq_count), 25);
`else
        chk_outs("freq off t=500 run held", 0, 1, 1, 0, 0);
        chk("freq off t=500 freq_count", int'(freq_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
